// File: rtl/bf16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bf16_pkg
// Description : Shared types and constants for the BF16 conversion scheduler.
//               This file holds the scheduler FSM state encoding, the
//               converter flag bit positions and the operand/result widths.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package bf16_pkg;

    localparam int BF16_W    = 16;
    localparam int FP32_W    = 32;
    localparam int NUM_FLAGS = 4;

    // Converter status flag bit positions
    localparam int FLAG_NAN  = 0;
    localparam int FLAG_INF  = 1;
    localparam int FLAG_ZERO = 2;
    localparam int FLAG_SUB  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } cvt_state_e;

endpackage
`default_nettype wire

// File: rtl/bf16_to_fp32.sv
`default_nettype none
// ============================================================================
// Module      : bf16_to_fp32
// Description : Pipelined BF16 -> FP32 widening converter with status flags.
//               The operand is captured on instruction_enable; result and
//               flags are valid LATENCY cycles after the enable cycle and
//               then hold until the next enable.
// Ports       : clk, rst_n (async active-low)
//               instruction_enable, operand_a[15:0]  - request
//               result[31:0], fpcsr[3:0]             - converted value, flags
// Revision    : 1.0 - initial release
// ============================================================================
module bf16_to_fp32
    import bf16_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instruction_enable,
    input  logic [BF16_W-1:0] operand_a,
    output logic [FP32_W-1:0] result,
    output logic [NUM_FLAGS-1:0] fpcsr
);

    logic [7:0]           w_exp;
    logic [6:0]           w_man;
    logic [NUM_FLAGS-1:0] w_flags;

    logic [FP32_W-1:0]    res_q [LATENCY];
    logic [NUM_FLAGS-1:0] flg_q [LATENCY];

    assign w_exp = operand_a[14:7];
    assign w_man = operand_a[6:0];

    always_comb begin
        w_flags            = '0;
        w_flags[FLAG_NAN]  = (w_exp == 8'hFF) && (w_man != 7'd0);
        w_flags[FLAG_INF]  = (w_exp == 8'hFF) && (w_man == 7'd0);
        w_flags[FLAG_ZERO] = (w_exp == 8'h00) && (w_man == 7'd0);
        w_flags[FLAG_SUB]  = (w_exp == 8'h00) && (w_man != 7'd0);
    end

    // Stage 0 loads on enable; later stages shift every cycle, so the last
    // stage settles to the stage-0 value LATENCY cycles after the enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                res_q[i] <= '0;
                flg_q[i] <= '0;
            end
        end else begin
            if (instruction_enable) begin
                res_q[0] <= {operand_a, 16'h0000};
                flg_q[0] <= w_flags;
            end
            for (int i = 1; i < LATENCY; i++) begin
                res_q[i] <= res_q[i-1];
                flg_q[i] <= flg_q[i-1];
            end
        end
    end

    assign result = res_q[LATENCY-1];
    assign fpcsr  = flg_q[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. Grants the first asserted
//               request at or above ptr_i, wrapping past NUM_REQ-1 to 0.
// Ports       : req_i[NUM_REQ-1:0]   - request vector
//               ptr_i                - highest-priority index this cycle
//               gnt_o[NUM_REQ-1:0]   - one-hot grant (zero if no request)
//               gnt_idx_o            - binary index of the grant
//               gnt_any_o            - at least one request asserted
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               gnt_any_o
);

    logic [IDX_W-1:0] w_cand;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        gnt_any_o = 1'b0;
        w_cand    = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            w_cand = IDX_W'((int'(ptr_i) + off) % NUM_REQ);
            if (!gnt_any_o && req_i[w_cand]) begin
                gnt_any_o     = 1'b1;
                gnt_o[w_cand] = 1'b1;
                gnt_idx_o     = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bf16_cvt_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : bf16_cvt_scheduler
// Description : Shares one BF16->FP32 converter among NUM_REQ requesters.
//               Round-robin accept, one-cycle converter enable, fixed-latency
//               capture, single response channel, sticky status flags.
// Ports       : clk, reset (async active-low)
//               req_valid/req_ready/req_operand/req_tag - request channels
//               rsp_valid/rsp_ready/rsp_result/rsp_src/rsp_tag/rsp_flags
//               cvt_enable/cvt_operand/cvt_result/cvt_fpcsr - converter
//               fpcsr_sticky, fpcsr_clr - accumulated flags and clear
//               busy - FSM not idle
// Revision    : 1.0 - initial release
// ============================================================================
module bf16_cvt_scheduler
    import bf16_pkg::*;
#(
    parameter  int NUM_REQ     = 2,
    parameter  int TAG_W       = 4,
    parameter  int CVT_LATENCY = 1,
    localparam int SRC_W       = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*BF16_W-1:0]  req_operand,
    input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [FP32_W-1:0]          rsp_result,
    output logic [SRC_W-1:0]           rsp_src,
    output logic [TAG_W-1:0]           rsp_tag,
    output logic [NUM_FLAGS-1:0]       rsp_flags,
    output logic                       cvt_enable,
    output logic [BF16_W-1:0]          cvt_operand,
    input  logic [FP32_W-1:0]          cvt_result,
    input  logic [NUM_FLAGS-1:0]       cvt_fpcsr,
    output logic [NUM_FLAGS-1:0]       fpcsr_sticky,
    input  logic                       fpcsr_clr,
    output logic                       busy
);

    localparam int CNT_W = $clog2(CVT_LATENCY + 1);

    cvt_state_e           state_q,  state_d;
    logic [SRC_W-1:0]     ptr_q,    ptr_d;
    logic [CNT_W-1:0]     cnt_q,    cnt_d;
    logic [BF16_W-1:0]    op_q,     op_d;
    logic [TAG_W-1:0]     tag_q,    tag_d;
    logic [SRC_W-1:0]     src_q,    src_d;
    logic [FP32_W-1:0]    result_q, result_d;
    logic [NUM_FLAGS-1:0] flags_q,  flags_d;
    logic [NUM_FLAGS-1:0] sticky_q, sticky_d;

    logic [NUM_REQ-1:0]   w_gnt;
    logic [SRC_W-1:0]     w_gnt_idx;
    logic                 w_gnt_any;
    logic [BF16_W-1:0]    w_sel_op;
    logic [TAG_W-1:0]     w_sel_tag;
    logic                 w_capture;

    rr_arbiter #(
        .NUM_REQ   (NUM_REQ)
    ) u_arb (
        .req_i     (req_valid),
        .ptr_i     (ptr_q),
        .gnt_o     (w_gnt),
        .gnt_idx_o (w_gnt_idx),
        .gnt_any_o (w_gnt_any)
    );

    // Payload mux for the granted requester (constant slices only)
    always_comb begin
        w_sel_op  = '0;
        w_sel_tag = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt_idx == SRC_W'(i)) begin
                w_sel_op  = req_operand[i*BF16_W +: BF16_W];
                w_sel_tag = req_tag[i*TAG_W +: TAG_W];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        tag_d      = tag_q;
        src_d      = src_q;
        result_d   = result_q;
        flags_d    = flags_q;
        req_ready  = '0;
        cvt_enable = 1'b0;
        w_capture  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // The reset term keeps req_ready low while reset is held,
                // since the grant itself is purely combinational.
                if (w_gnt_any && reset) begin
                    req_ready = w_gnt;
                    op_d      = w_sel_op;
                    tag_d     = w_sel_tag;
                    src_d     = w_gnt_idx;
                    ptr_d     = (w_gnt_idx == SRC_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cvt_enable = 1'b1;
                cnt_d      = CNT_W'(CVT_LATENCY);
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                // Converter output is valid in the cycle the count reads 1
                if (cnt_q == CNT_W'(1)) begin
                    w_capture = 1'b1;
                    result_d  = cvt_result;
                    flags_d   = cvt_fpcsr;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A clear coinciding with a capture keeps only the new flags
        sticky_d = sticky_q;
        if (w_capture) begin
            sticky_d = fpcsr_clr ? cvt_fpcsr : (sticky_q | cvt_fpcsr);
        end else if (fpcsr_clr) begin
            sticky_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            tag_q    <= '0;
            src_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
            sticky_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            tag_q    <= tag_d;
            src_q    <= src_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            sticky_q <= sticky_d;
        end
    end

    assign rsp_valid    = (state_q == ST_RESP);
    assign busy         = (state_q != ST_IDLE);
    assign cvt_operand  = op_q;
    assign rsp_result   = result_q;
    assign rsp_src      = src_q;
    assign rsp_tag      = tag_q;
    assign rsp_flags    = flags_q;
    assign fpcsr_sticky = sticky_q;

endmodule
`default_nettype wire
